npc_gen: RTL and testbench

- Parametrised next-PC generator for the multicycle core, sitting between EXU (upstream) and IFU (downstream).
- Accepts one resolved instruction outcome per valid/ready handshake and registers the next PC.
- Selects among interrupt, ecall, mret, jump, branch and sequential targets; detects misaligned targets.
- Presents a trap record to the CSR unit and keeps a saturating redirect counter.

---
 rtl/npc_gen.sv | 161 ++++++++++++++++
 tb/tb_npc_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/npc_gen.sv
// Next-PC generator: registers one resolved EXU outcome per handshake and
// holds the chosen next PC, trap record and redirect count for the IFU/CSR side.
module npc_gen #(
    parameter int XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int C_EXT       = 0,
    parameter int ECALL_CAUSE = 11,
    parameter int IRQ_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  snpc,
    input  logic             branch_flag,
    input  logic [XLEN-1:0]  branch_pc,
    input  logic             jump_flag,
    input  logic [XLEN-1:0]  exu_res,
    input  logic             is_ecall,
    input  logic             is_mret,
    input  logic             irq_pending,
    input  logic [IRQ_W-1:0] irq_cause,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  dnpc,
    output logic             trap_valid,
    output logic [XLEN-1:0]  trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic [XLEN-1:0]  trap_tval,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {IDLE, VALID} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  dnpc_q, dnpc_d;
    logic             trap_valid_q, trap_valid_d;
    logic [XLEN-1:0]  trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]  trap_epc_q, trap_epc_d;
    logic [XLEN-1:0]  trap_tval_q, trap_tval_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Outcome of the instruction currently presented on the inputs
    logic [XLEN-1:0]  sel_npc, sel_cause, sel_tval, jmp_tgt, tvec_base;
    logic             sel_trap, sel_irq, sel_redirect;

    function automatic logic misaligned(input logic [XLEN-1:0] t);
        if (C_EXT != 0) return t[0];
        return |t[1:0];
    endfunction

    always_comb begin
        sel_trap     = 1'b0;
        sel_irq      = 1'b0;
        sel_redirect = 1'b1;
        sel_cause    = '0;
        sel_tval     = '0;
        sel_npc      = snpc;
        jmp_tgt      = exu_res;
        jmp_tgt[0]   = 1'b0;
        tvec_base    = {mtvec[XLEN-1:2], 2'b00};

        if (irq_pending) begin
            sel_trap  = 1'b1;
            sel_irq   = 1'b1;
            sel_cause = {1'b1, {(XLEN-1-IRQ_W){1'b0}}, irq_cause};
        end else if (is_ecall) begin
            sel_trap  = 1'b1;
            sel_cause = XLEN'(ECALL_CAUSE);
        end else if (is_mret) begin
            sel_npc = mepc;
        end else if (jump_flag) begin
            if (misaligned(jmp_tgt)) begin
                sel_trap = 1'b1;
                sel_tval = jmp_tgt;
            end else begin
                sel_npc = jmp_tgt;
            end
        end else if (branch_flag) begin
            if (misaligned(branch_pc)) begin
                sel_trap = 1'b1;
                sel_tval = branch_pc;
            end else begin
                sel_npc = branch_pc;
            end
        end else begin
            sel_redirect = 1'b0;
        end

        // Vectored mode only offsets interrupts; modes 2/3 behave as direct
        if (sel_trap) begin
            if (sel_irq && (mtvec[1:0] == 2'b01))
                sel_npc = tvec_base + {{(XLEN-IRQ_W-2){1'b0}}, irq_cause, 2'b00};
            else
                sel_npc = tvec_base;
        end
    end

    always_comb begin
        state_d      = state_q;
        dnpc_d       = dnpc_q;
        trap_valid_d = trap_valid_q;
        trap_cause_d = trap_cause_q;
        trap_epc_d   = trap_epc_q;
        trap_tval_d  = trap_tval_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d      = VALID;
                    dnpc_d       = sel_npc;
                    trap_valid_d = sel_trap;
                    trap_cause_d = sel_cause;
                    trap_epc_d   = sel_trap ? pc : '0;
                    trap_tval_d  = sel_tval;
                    if (sel_redirect && (cnt_q != {CNT_W{1'b1}}))
                        cnt_d = cnt_q + 1'b1;
                end
            end
            VALID: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dnpc_q       <= RESET_PC;
            trap_valid_q <= 1'b0;
            trap_cause_q <= '0;
            trap_epc_q   <= '0;
            trap_tval_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            dnpc_q       <= dnpc_d;
            trap_valid_q <= trap_valid_d;
            trap_cause_q <= trap_cause_d;
            trap_epc_q   <= trap_epc_d;
            trap_tval_q  <= trap_tval_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == VALID);
    assign dnpc         = dnpc_q;
    assign trap_valid   = trap_valid_q;
    assign trap_cause   = trap_cause_q;
    assign trap_epc     = trap_epc_q;
    assign trap_tval    = trap_tval_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_npc_gen.sv
// Bench for npc_gen: two instances (32-bit align / 16-bit counter, and
// 16-bit align / 2-bit counter) driven by shared inputs and checked against a model.
module tb_npc_gen;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] pc, snpc, branch_pc, exu_res, mtvec, mepc;
    logic        branch_flag, jump_flag, is_ecall, is_mret, irq_pending;
    logic [3:0]  irq_cause;

    logic        o_in_ready[2], o_out_valid[2], o_trap_valid[2];
    logic [31:0] o_dnpc[2], o_cause[2], o_epc[2], o_tval[2];
    logic [15:0] o_cnt0;
    logic [1:0]  o_cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npc_gen #(.C_EXT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[0]),
        .pc(pc), .snpc(snpc), .branch_flag(branch_flag), .branch_pc(branch_pc),
        .jump_flag(jump_flag), .exu_res(exu_res), .is_ecall(is_ecall), .is_mret(is_mret),
        .irq_pending(irq_pending), .irq_cause(irq_cause), .mtvec(mtvec), .mepc(mepc),
        .out_valid(o_out_valid[0]), .out_ready(out_ready), .dnpc(o_dnpc[0]),
        .trap_valid(o_trap_valid[0]), .trap_cause(o_cause[0]), .trap_epc(o_epc[0]),
        .trap_tval(o_tval[0]), .redirect_cnt(o_cnt0)
    );

    npc_gen #(.C_EXT(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[1]),
        .pc(pc), .snpc(snpc), .branch_flag(branch_flag), .branch_pc(branch_pc),
        .jump_flag(jump_flag), .exu_res(exu_res), .is_ecall(is_ecall), .is_mret(is_mret),
        .irq_pending(irq_pending), .irq_cause(irq_cause), .mtvec(mtvec), .mepc(mepc),
        .out_valid(o_out_valid[1]), .out_ready(out_ready), .dnpc(o_dnpc[1]),
        .trap_valid(o_trap_valid[1]), .trap_cause(o_cause[1]), .trap_epc(o_epc[1]),
        .trap_tval(o_tval[1]), .redirect_cnt(o_cnt1)
    );

    // Model state: one pending-result flag shared by both instances
    bit          m_busy;
    logic [31:0] m_dnpc[2], m_cause[2], m_epc[2], m_tval[2];
    logic        m_trap[2];
    int          m_cnt[2];
    int          cnt_max[2] = '{65535, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next-PC rules written straight from the priority list; ic=1 means 16-bit alignment
    function automatic void ref_out(input int ic, output logic [31:0] d, output logic t,
                                    output logic [31:0] ca, output logic [31:0] ep,
                                    output logic [31:0] tv, output bit rd);
        logic [31:0] tgt, base;
        bit mis;
        base = mtvec & ~32'h3;
        t = 0; ca = 0; ep = 0; tv = 0; rd = 1; d = snpc;
        if (irq_pending) begin
            t = 1; ca = 32'h8000_0000 | 32'(irq_cause);
        end else if (is_ecall) begin
            t = 1; ca = 11;
        end else if (is_mret) begin
            d = mepc;
        end else if (jump_flag || branch_flag) begin
            tgt = jump_flag ? (exu_res & ~32'h1) : branch_pc;
            mis = (ic == 1) ? (tgt % 2 != 0) : (tgt % 4 != 0);
            if (mis) begin t = 1; tv = tgt; end
            else d = tgt;
        end else begin
            rd = 0;
        end
        if (t) begin
            ep = pc;
            d = (irq_pending && (mtvec % 4 == 1)) ? base + 32'(4 * irq_cause) : base;
        end
    endfunction

    task automatic cyc();
        logic [31:0] d, ca, ep, tv;
        logic t;
        bit rd;
        if (rst) begin
            m_busy = 0;
            for (int i = 0; i < 2; i++) begin
                m_dnpc[i] = 32'h8000_0000; m_trap[i] = 0; m_cause[i] = 0;
                m_epc[i] = 0; m_tval[i] = 0; m_cnt[i] = 0;
            end
        end else if (!m_busy && in_valid) begin
            m_busy = 1;
            for (int i = 0; i < 2; i++) begin
                ref_out(i, d, t, ca, ep, tv, rd);
                m_dnpc[i] = d; m_trap[i] = t; m_cause[i] = ca; m_epc[i] = ep; m_tval[i] = tv;
                if (rd && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            end
        end else if (m_busy && out_ready) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready%0d", i), 32'(o_in_ready[i]), 32'(!m_busy));
            chk($sformatf("out_valid%0d", i), 32'(o_out_valid[i]), 32'(m_busy));
            chk($sformatf("dnpc%0d", i), o_dnpc[i], m_dnpc[i]);
            chk($sformatf("trap_valid%0d", i), 32'(o_trap_valid[i]), 32'(m_trap[i]));
            chk($sformatf("trap_cause%0d", i), o_cause[i], m_cause[i]);
            chk($sformatf("trap_epc%0d", i), o_epc[i], m_epc[i]);
            chk($sformatf("trap_tval%0d", i), o_tval[i], m_tval[i]);
        end
        chk("cnt0", 32'(o_cnt0), 32'(m_cnt[0]));
        chk("cnt1", 32'(o_cnt1), 32'(m_cnt[1]));
    endtask

    task automatic clr();
        in_valid = 0; out_ready = 0; branch_flag = 0; jump_flag = 0;
        is_ecall = 0; is_mret = 0; irq_pending = 0; irq_cause = 0;
    endtask

    task automatic drain();
        clr();
        out_ready = 1;
        cyc();
        out_ready = 0;
    endtask

    initial begin
        clr();
        rst = 1; pc = 0; snpc = 0; branch_pc = 0; exu_res = 0; mtvec = 0; mepc = 0;
        cyc(); cyc();
        rst = 0;
        out_ready = 1;           // ignored while idle
        cyc();
        chk("rst_dnpc", o_dnpc[0], 32'h8000_0000);
        chk("rst_out_valid", 32'(o_out_valid[0]), 32'd0);
        chk("rst_in_ready", 32'(o_in_ready[0]), 32'd1);
        chk("rst_cnt", 32'(o_cnt0), 32'd0);
        out_ready = 0;

        // Sequential outcome held for three cycles of back-pressure
        pc = 32'h8000_0000; snpc = 32'h8000_0004; in_valid = 1;
        cyc();
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("seq_hold_dnpc", o_dnpc[0], 32'h8000_0004);
            chk("seq_hold_in_ready", 32'(o_in_ready[0]), 32'd0);
        end
        drain();
        chk("seq_cnt", 32'(o_cnt0), 32'd0);

        // Jump beats branch, bit0 of the jump target cleared
        jump_flag = 1; branch_flag = 1; exu_res = 32'h8000_0101; branch_pc = 32'h8000_0200;
        in_valid = 1;
        cyc();
        chk("jump_dnpc", o_dnpc[0], 32'h8000_0100);
        drain();

        // Ecall beats mret
        is_ecall = 1; is_mret = 1; mtvec = 32'h8000_1000; pc = 32'h8000_0010;
        mepc = 32'h8000_0014; in_valid = 1;
        cyc();
        chk("ecall_dnpc", o_dnpc[0], 32'h8000_1000);
        chk("ecall_cause", o_cause[0], 32'd11);
        chk("ecall_epc", o_epc[0], 32'h8000_0010);
        drain();

        is_mret = 1; in_valid = 1;
        cyc();
        chk("mret_dnpc", o_dnpc[0], 32'h8000_0014);
        drain();

        // Halfword-aligned branch: trap on dut0, taken on dut1
        branch_flag = 1; branch_pc = 32'h8000_0102; in_valid = 1;
        cyc();
        chk("mis_trap0", 32'(o_trap_valid[0]), 32'd1);
        chk("mis_cause0", o_cause[0], 32'd0);
        chk("mis_tval0", o_tval[0], 32'h8000_0102);
        chk("mis_dnpc0", o_dnpc[0], 32'h8000_1000);
        chk("mis_dnpc1", o_dnpc[1], 32'h8000_0102);
        chk("mis_trap1", 32'(o_trap_valid[1]), 32'd0);
        drain();

        // Vectored interrupt beats ecall
        mtvec = 32'h8000_1001; irq_pending = 1; irq_cause = 4'd7; is_ecall = 1; in_valid = 1;
        cyc();
        chk("irq_dnpc", o_dnpc[0], 32'h8000_101C);
        chk("irq_cause", o_cause[0], 32'h8000_0007);
        drain();

        // Reset while a result is pending
        in_valid = 1;
        cyc();
        in_valid = 0; rst = 1;
        cyc();
        rst = 0;
        chk("rst_valid_dnpc", o_dnpc[0], 32'h8000_0000);
        chk("rst_valid_ov", 32'(o_out_valid[0]), 32'd0);

        // Five aligned branches saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            branch_flag = 1; branch_pc = 32'h8000_0040 + 32'(k * 4); in_valid = 1;
            cyc();
            drain();
        end
        chk("sat_cnt1", 32'(o_cnt1), 32'd3);
        chk("cnt0_after5", 32'(o_cnt0), 32'd5);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            out_ready   = ($urandom_range(0, 1) != 0);
            irq_pending = ($urandom_range(0, 9) == 0);
            is_ecall    = ($urandom_range(0, 7) == 0);
            is_mret     = ($urandom_range(0, 6) == 0);
            jump_flag   = ($urandom_range(0, 3) == 0);
            branch_flag = ($urandom_range(0, 2) == 0);
            irq_cause   = 4'($urandom);
            pc          = $urandom;
            snpc        = pc + 4;
            branch_pc   = $urandom;
            exu_res     = $urandom;
            mtvec       = $urandom;
            mepc        = $urandom;
            rst         = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
